// File: rtl/fifo_pkg.sv
// Shared constants and drain FSM encoding for the FIFO-to-byte-stream drain.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 32;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned IDX_W       = 2;

    typedef logic [IDX_W-1:0] byte_idx_t;

    // Legacy-compatible encoding: plain 2-bit vector with named constants.
    typedef logic [1:0] drain_state_t;

    localparam drain_state_t ST_IDLE = 2'd0;
    localparam drain_state_t ST_READ = 2'd1;
    localparam drain_state_t ST_LOAD = 2'd2;
    localparam drain_state_t ST_SEND = 2'd3;

    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/fifo_drain_bytesel.sv
// Combinational byte-lane selector: picks one byte of a 32-bit word by index and byte order.
module fifo_drain_bytesel
    import fifo_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [FIFO_DATA_W-1:0] word,
    input  byte_idx_t              idx,
    output logic [BYTE_W-1:0]      sel
);

    byte_idx_t lane;

    // Index 0 maps to the most significant lane when sending MSB first.
    always_comb begin
        lane = MSB_FIRST ? byte_idx_t'(2'd3 - idx) : idx;
    end

    always_comb begin
        sel = '0;
        unique case (lane)
            2'd0: sel = word[7:0];
            2'd1: sel = word[15:8];
            2'd2: sel = word[23:16];
            2'd3: sel = word[31:24];
            default: sel = '0;
        endcase
    end

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops 32-bit words from an upstream FIFO and serialises them as a byte stream.
// Define FIFO_DRAIN_PARITY_EN to add the byte_par even-parity output.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   EN,
    input  logic                   fifo_empty,
    input  logic [FIFO_DATA_W-1:0] fifo_data,
    output logic                   fifo_rd,
    output logic [BYTE_W-1:0]      byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic [15:0]            words_sent
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic                   byte_par
`endif
);

    drain_state_t           state_q, state_d;
    logic [FIFO_DATA_W-1:0] word_q, word_d;
    byte_idx_t              idx_q, idx_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [BYTE_W-1:0]      sel_byte;
    logic                   more_words;

    assign more_words = EN && !fifo_empty;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (more_words) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // fifo_data is valid one cycle after the pop strobe.
                word_d  = fifo_data;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (byte_ready) begin
                    if (idx_q == byte_idx_t'(2'd3)) begin
                        cnt_d   = cnt_q + 16'd1;
                        state_d = more_words ? ST_READ : ST_IDLE;
                    end else begin
                        idx_d = idx_q + byte_idx_t'(2'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    fifo_drain_bytesel #(
        .MSB_FIRST (MSB_FIRST)
    ) u_bytesel (
        .word (word_q),
        .idx  (idx_q),
        .sel  (sel_byte)
    );

    always_comb begin
        fifo_rd    = (state_q == ST_READ);
        byte_valid = (state_q == ST_SEND);
        busy       = (state_q != ST_IDLE);
        byte_out   = byte_valid ? sel_byte : '0;
        words_sent = cnt_q;
    end

`ifdef FIFO_DRAIN_PARITY_EN
    // byte_out is forced to zero outside SEND, so parity is zero there too.
    always_comb begin
        byte_par = even_parity(byte_out);
    end
`endif

endmodule
